decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// Instruction decode stage: splits a 16-bit instruction into control bits and
// operand values, forwards pending exe/mem writebacks into the operands, owns
// the register file, and inserts one bubble after a load-use hazard.
module decode_unit #(
   parameter int XLEN = 16,
   parameter int PC_W = 8,
   parameter int NREG = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [10:0]     out_ctrl,
   output logic [XLEN-1:0] out_val1,
   output logic [XLEN-1:0] out_val2,
   output logic [XLEN-1:0] out_val3,
   output logic [PC_W-1:0] out_jump_addr,
   input  logic            flush,
   output logic            halted,
   input  logic            exe_wr_en,
   input  logic [3:0]      exe_wr_addr,
   input  logic [XLEN-1:0] exe_wr_data,
   input  logic            mem_wr_en,
   input  logic [3:0]      mem_wr_addr,
   input  logic [XLEN-1:0] mem_wr_data
);

   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

   // out_ctrl bit order: {add,sub,and,or,gt,eq,mem_read,mem_write,reg_write,branch,jump}
   localparam logic [10:0] CTL_ADD  = 11'h400;
   localparam logic [10:0] CTL_SUB  = 11'h200;
   localparam logic [10:0] CTL_AND  = 11'h100;
   localparam logic [10:0] CTL_OR   = 11'h080;
   localparam logic [10:0] CTL_GT   = 11'h040;
   localparam logic [10:0] CTL_EQ   = 11'h020;
   localparam logic [10:0] CTL_MRD  = 11'h010;
   localparam logic [10:0] CTL_MWR  = 11'h008;
   localparam logic [10:0] CTL_RWR  = 11'h004;
   localparam logic [10:0] CTL_BR   = 11'h002;
   localparam logic [10:0] CTL_JMP  = 11'h001;

   typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

   state_t            state_reg;
   logic              out_valid_reg;
   logic [10:0]       out_ctrl_reg;
   logic [XLEN-1:0]   out_val1_reg, out_val2_reg, out_val3_reg;
   logic [PC_W-1:0]   out_jump_addr_reg;
   logic              halted_reg;
   logic [IW-1:0]     held_idx_reg;
   logic [XLEN-1:0]   regs_reg [NREG];

   logic [3:0]        op, rd_f, rs_f, rt_f;
   logic [IW-1:0]     rd_idx, rs_idx;
   logic [XLEN-1:0]   r_rd, r_rs;
   logic [PC_W-1:0]   br_target;
   logic              dec_valid, dec_halt, reads_rd, reads_rs;
   logic [10:0]       dec_ctrl;
   logic [XLEN-1:0]   dec_val1, dec_val2, dec_val3;
   logic [PC_W-1:0]   dec_jump;
   logic              load_use, accept;

   assign op     = in_inst[15:12];
   assign rd_f   = in_inst[11:8];
   assign rs_f   = in_inst[7:4];
   assign rt_f   = in_inst[3:0];
   assign rd_idx = rd_f[IW-1:0];
   assign rs_idx = rs_f[IW-1:0];

   // Operand read with bypass: the exe-stage result is newer than the mem-stage one
   assign r_rd = (exe_wr_en && exe_wr_addr == 4'(rd_idx)) ? exe_wr_data :
                 (mem_wr_en && mem_wr_addr == 4'(rd_idx)) ? mem_wr_data : regs_reg[rd_idx];
   assign r_rs = (exe_wr_en && exe_wr_addr == 4'(rs_idx)) ? exe_wr_data :
                 (mem_wr_en && mem_wr_addr == 4'(rs_idx)) ? mem_wr_data : regs_reg[rs_idx];

   // Branch target wraps modulo 2^PC_W; rt is a signed 4-bit displacement
   assign br_target = in_pc + PC_W'($signed(rt_f));

   // Instruction decode: control word, operand values and which registers are read
   always_comb begin
      dec_valid = 1'b0;
      dec_halt  = 1'b0;
      dec_ctrl  = '0;
      dec_val1  = '0;
      dec_val2  = '0;
      dec_val3  = '0;
      dec_jump  = '0;
      reads_rd  = 1'b0;
      reads_rs  = 1'b0;
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_RWR | ((op == 4'h1) ? CTL_ADD : (op == 4'h2) ? CTL_SUB :
                                   (op == 4'h3) ? CTL_AND : CTL_OR);
            dec_val1  = r_rd;
            dec_val2  = r_rs;
            dec_val3  = XLEN'(rd_f);
            reads_rd  = 1'b1;
            reads_rs  = 1'b1;
         end
         4'h5, 4'h6, 4'h7: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_RWR | ((op == 4'h6) ? CTL_SUB : CTL_ADD);
            dec_val1  = r_rd;
            dec_val2  = (op == 4'h7) ? XLEN'(1) : XLEN'($signed(in_inst[7:0]));
            dec_val3  = XLEN'(rd_f);
            reads_rd  = 1'b1;
         end
         4'h8: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_MRD | CTL_RWR;
            dec_val1  = XLEN'(in_inst[7:0]);
            dec_val3  = XLEN'(rd_f);
         end
         4'h9: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_MRD | CTL_RWR;
            dec_val1  = r_rs;
            dec_val2  = XLEN'(rt_f);
            dec_val3  = XLEN'(rd_f);
            reads_rs  = 1'b1;
         end
         4'hA: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_MWR;
            dec_val1  = r_rs;
            dec_val2  = XLEN'(rt_f);
            dec_val3  = r_rd;
            reads_rd  = 1'b1;
            reads_rs  = 1'b1;
         end
         4'hC, 4'hD: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_BR | ((op == 4'hC) ? CTL_EQ : CTL_GT);
            dec_val1  = r_rd;
            dec_val2  = r_rs;
            dec_val3  = XLEN'(br_target);
            reads_rd  = 1'b1;
            reads_rs  = 1'b1;
         end
         4'hE: begin
            dec_valid = 1'b1;
            dec_ctrl  = CTL_JMP;
            dec_jump  = PC_W'(r_rd);
            reads_rd  = 1'b1;
         end
         4'hF: dec_halt = 1'b1;
         default: ;
      endcase
   end

   // A held load whose destination the offered instruction reads must not be bypassed
   assign load_use = out_valid_reg && out_ctrl_reg[4] && in_valid &&
                     ((reads_rd && rd_idx == held_idx_reg) || (reads_rs && rs_idx == held_idx_reg));
   assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready) && !load_use && !flush;
   assign accept   = in_valid && in_ready;

   // Register file: written every edge; exe wins over mem on the same address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (exe_wr_en && exe_wr_addr == 4'(i))
               regs_reg[i] <= exe_wr_data;
            else if (mem_wr_en && mem_wr_addr == 4'(i))
               regs_reg[i] <= mem_wr_data;
         end
      end
   end

   // Control FSM and output register; outputs change only on accept, flush or drain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= RUN;
         out_valid_reg     <= 1'b0;
         out_ctrl_reg      <= '0;
         out_val1_reg      <= '0;
         out_val2_reg      <= '0;
         out_val3_reg      <= '0;
         out_jump_addr_reg <= '0;
         halted_reg        <= 1'b0;
         held_idx_reg      <= '0;
      end else if (flush && state_reg != HALTED) begin
         out_valid_reg <= 1'b0;
         state_reg     <= RUN;
      end else begin
         case (state_reg)
            RUN: begin
               if (accept) begin
                  out_valid_reg     <= dec_valid;
                  out_ctrl_reg      <= dec_ctrl;
                  out_val1_reg      <= dec_val1;
                  out_val2_reg      <= dec_val2;
                  out_val3_reg      <= dec_val3;
                  out_jump_addr_reg <= dec_jump;
                  held_idx_reg      <= rd_idx;
                  if (dec_halt) begin
                     state_reg  <= HALTED;
                     halted_reg <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  if (load_use) state_reg <= STALL;
               end
            end
            STALL:   state_reg <= RUN;
            default: out_valid_reg <= 1'b0;
         endcase
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_ctrl      = out_ctrl_reg;
   assign out_val1      = out_val1_reg;
   assign out_val2      = out_val2_reg;
   assign out_val3      = out_val3_reg;
   assign out_jump_addr = out_jump_addr_reg;
   assign halted        = halted_reg;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed scenarios with literal expectations, then
// randomized traffic checked each cycle against a behavioural model.
module tb_decode_unit;

   localparam int XLEN = 16;
   localparam int PC_W = 8;

   localparam int unsigned C_ADD = 32'h400, C_SUB = 32'h200, C_EQ = 32'h020, C_MRD = 32'h010;
   localparam int unsigned C_MWR = 32'h008, C_RWR = 32'h004, C_BR = 32'h002, C_JMP = 32'h001;
   localparam int unsigned C_GT  = 32'h040;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0, in_ready;
   logic [15:0]     in_inst = '0;
   logic [PC_W-1:0] in_pc = '0;
   logic            out_valid, out_ready = 1'b0;
   logic [10:0]     out_ctrl;
   logic [XLEN-1:0] out_val1, out_val2, out_val3;
   logic [PC_W-1:0] out_jump_addr;
   logic            flush = 1'b0, halted;
   logic            exe_wr_en = 1'b0, mem_wr_en = 1'b0;
   logic [3:0]      exe_wr_addr = '0, mem_wr_addr = '0;
   logic [XLEN-1:0] exe_wr_data = '0, mem_wr_data = '0;

   always #5 clk = ~clk;

   decode_unit #(.XLEN(XLEN), .PC_W(PC_W), .NREG(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_val1(out_val1), .out_val2(out_val2), .out_val3(out_val3),
      .out_jump_addr(out_jump_addr), .flush(flush), .halted(halted),
      .exe_wr_en(exe_wr_en), .exe_wr_addr(exe_wr_addr), .exe_wr_data(exe_wr_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data));

   int checks = 0;
   int failures = 0;

   // stimulus for the next cycle
   logic            s_valid, s_ordy, s_flush, s_ee, s_me;
   logic [15:0]     s_inst;
   logic [PC_W-1:0] s_pc;
   logic [3:0]      s_ea, s_ma;
   logic [XLEN-1:0] s_ed, s_md;

   // behavioural model state
   int unsigned m_rf [16];
   bit          m_valid;
   int unsigned m_ctrl, m_v1, m_v2, m_v3, m_ja, m_dest;
   int          m_mode;          // 0 running, 1 bubble after load-use, 2 halted
   bit          exp_rdy, exp_lu, last_rdy;

   typedef struct {
      bit          valid, halt, rdu, rsu;
      int unsigned ctrl, v1, v2, v3, ja, rd, rs;
   } dec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned opnd(input int unsigned x);
      if (exe_wr_en && 32'(exe_wr_addr) == x) return 32'(exe_wr_data);
      if (mem_wr_en && 32'(mem_wr_addr) == x) return 32'(mem_wr_data);
      return m_rf[x];
   endfunction

   function automatic dec_t decode_model(input logic [15:0] inst, input int unsigned pc);
      dec_t d;
      int unsigned op, imm, rt;
      op   = 32'(inst[15:12]);
      d    = '{default: 0};
      d.rd = 32'(inst[11:8]);
      d.rs = 32'(inst[7:4]);
      rt   = 32'(inst[3:0]);
      imm  = 32'(inst[7:0]);
      d.valid = (op >= 1 && op <= 10) || (op >= 12 && op <= 14);
      case (op)
         1, 2, 3, 4: begin
            d.ctrl = (32'd1 << (11 - op)) | C_RWR;
            d.v1 = opnd(d.rd); d.v2 = opnd(d.rs); d.v3 = d.rd; d.rdu = 1; d.rsu = 1;
         end
         5, 6, 7: begin
            d.ctrl = ((op == 6) ? C_SUB : C_ADD) | C_RWR;
            d.v1 = opnd(d.rd); d.v3 = d.rd; d.rdu = 1;
            d.v2 = (op == 7) ? 1 : ((imm >= 128) ? imm + 32'hFF00 : imm);
         end
         8:  begin d.ctrl = C_MRD | C_RWR; d.v1 = imm; d.v3 = d.rd; end
         9:  begin d.ctrl = C_MRD | C_RWR; d.v1 = opnd(d.rs); d.v2 = rt; d.v3 = d.rd; d.rsu = 1; end
         10: begin
            d.ctrl = C_MWR; d.v1 = opnd(d.rs); d.v2 = rt; d.v3 = opnd(d.rd); d.rdu = 1; d.rsu = 1;
         end
         12, 13: begin
            d.ctrl = C_BR | ((op == 12) ? C_EQ : C_GT);
            d.v1 = opnd(d.rd); d.v2 = opnd(d.rs); d.rdu = 1; d.rsu = 1;
            d.v3 = (pc + ((rt >= 8) ? rt + 240 : rt)) % 256;
         end
         14: begin d.ctrl = C_JMP; d.ja = opnd(d.rd) % 256; d.rdu = 1; end
         15: d.halt = 1;
         default: ;
      endcase
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
      m_valid = 0; m_mode = 0; m_dest = 0;
      m_ctrl = 0; m_v1 = 0; m_v2 = 0; m_v3 = 0; m_ja = 0;
   endtask

   task automatic idle_stim();
      s_valid = 0; s_inst = '0; s_pc = '0; s_ordy = 1; s_flush = 0;
      s_ee = 0; s_ea = '0; s_ed = '0; s_me = 0; s_ma = '0; s_md = '0;
   endtask

   // per-cycle comparison of the DUT against the model
   task automatic compare();
      dec_t d;
      d = decode_model(in_inst, 32'(in_pc));
      exp_lu  = m_valid && ((m_ctrl & C_MRD) != 0) && in_valid &&
                ((d.rdu && d.rd == m_dest) || (d.rsu && d.rs == m_dest));
      exp_rdy = (m_mode == 0) && (!m_valid || out_ready) && !exp_lu && !flush;
      last_rdy = in_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("halted", 32'(halted), (m_mode == 2) ? 1 : 0);
      if (m_valid) begin
         chk("out_ctrl", 32'(out_ctrl), m_ctrl);
         chk("out_val1", 32'(out_val1), m_v1);
         chk("out_val2", 32'(out_val2), m_v2);
         chk("out_val3", 32'(out_val3), m_v3);
         chk("out_jump_addr", 32'(out_jump_addr), m_ja);
      end
   endtask

   task automatic model_update();
      dec_t d;
      d = decode_model(in_inst, 32'(in_pc));
      if (flush && m_mode != 2) begin
         m_valid = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (in_valid && exp_rdy) begin
            if (d.halt) begin
               m_valid = 0; m_mode = 2;
            end else begin
               m_valid = d.valid;
               m_ctrl = d.ctrl; m_v1 = d.v1; m_v2 = d.v2; m_v3 = d.v3; m_ja = d.ja;
               m_dest = d.rd;
            end
         end else if (out_ready) begin
            if (m_valid && exp_lu) m_mode = 1;
            m_valid = 0;
         end
      end else if (m_mode == 1) begin
         m_mode = 0;
      end
      if (mem_wr_en) m_rf[mem_wr_addr] = 32'(mem_wr_data);
      if (exe_wr_en) m_rf[exe_wr_addr] = 32'(exe_wr_data);
   endtask

   task automatic step();
      @(negedge clk);
      in_valid = s_valid; in_inst = s_inst; in_pc = s_pc; out_ready = s_ordy; flush = s_flush;
      exe_wr_en = s_ee; exe_wr_addr = s_ea; exe_wr_data = s_ed;
      mem_wr_en = s_me; mem_wr_addr = s_ma; mem_wr_data = s_md;
      #1;
      compare();
      $display("cyc t=%0t inst=%h v=%0b rdy=%0b ordy=%0b fl=%0b -> ov=%0b ctrl=%h v1=%h v2=%h v3=%h",
               $time, in_inst, in_valid, in_ready, out_ready, flush, out_valid, out_ctrl,
               out_val1, out_val2, out_val3);
      @(posedge clk);
      model_update();
      #1;
   endtask

   // asynchronous reset pulse, checked immediately while rst is low
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      in_valid = 0; flush = 0; exe_wr_en = 0; mem_wr_en = 0; out_ready = 1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_ctrl", 32'(out_ctrl), 0);
      chk("rst_val1", 32'(out_val1), 0);
      chk("rst_val2", 32'(out_val2), 0);
      chk("rst_val3", 32'(out_val3), 0);
      chk("rst_jump_addr", 32'(out_jump_addr), 0);
      chk("rst_halted", 32'(halted), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 1);
      idle_stim();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle_stim();
      model_reset();
      do_reset();

      // addi r1,#-3
      s_valid = 1; s_inst = 16'h51FD;
      step();
      chk("addi_accept", 32'(last_rdy), 1);
      chk("addi_valid", 32'(out_valid), 1);
      chk("addi_ctrl", 32'(out_ctrl), 32'h404);
      chk("addi_val2", 32'(out_val2), 32'hFFFD);
      chk("addi_val3", 32'(out_val3), 1);

      // same-cycle exe/mem writes to r2 forward the exe value, which is also stored
      s_inst = 16'h1320; s_ee = 1; s_ea = 4'd2; s_ed = 16'd7; s_me = 1; s_ma = 4'd2; s_md = 16'd9;
      step();
      chk("fwd_val2", 32'(out_val2), 7);
      s_ee = 0; s_me = 0; s_inst = 16'h1620;
      step();
      chk("rf_val2", 32'(out_val2), 7);

      // ld r4 then add r5,r4: hazard, one bubble cycle, then accepted
      s_inst = 16'h9412;
      step();
      chk("ld_ctrl", 32'(out_ctrl), 32'h014);
      s_inst = 16'h1540;
      step();
      chk("lu_in_ready", 32'(last_rdy), 0);
      chk("lu_drain_valid", 32'(out_valid), 0);
      step();
      chk("stall_in_ready", 32'(last_rdy), 0);
      chk("stall_valid", 32'(out_valid), 0);
      step();
      chk("after_stall_accept", 32'(last_rdy), 1);
      chk("after_stall_ctrl", 32'(out_ctrl), 32'h404);
      chk("after_stall_val3", 32'(out_val3), 5);

      // sub held under back-pressure for three cycles
      s_inst = 16'h2312;
      step();
      s_ordy = 0; s_inst = 16'h1111;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_in_ready", 32'(last_rdy), 0);
         chk("hold_ctrl", 32'(out_ctrl), 32'h204);
         chk("hold_val3", 32'(out_val3), 3);
      end
      s_ordy = 1;
      step();
      chk("hold_release_accept", 32'(last_rdy), 1);
      chk("hold_release_val3", 32'(out_val3), 1);

      // beq at pc 0xFE with rt=3 wraps to 0x01; flush squashes the next cycle
      s_inst = 16'hC123; s_pc = 8'hFE;
      step();
      chk("beq_ctrl", 32'(out_ctrl), 32'h022);
      chk("beq_val3", 32'(out_val3), 32'h01);
      s_inst = 16'h1111; s_flush = 1;
      step();
      chk("flush_in_ready", 32'(last_rdy), 0);
      chk("flush_valid", 32'(out_valid), 0);
      s_flush = 0;

      // reset in the middle of a stall
      s_inst = 16'h9700;
      step();
      s_inst = 16'h1070;
      step();
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         s_valid = ($urandom_range(0, 3) != 0);
         s_inst  = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15))};
         s_pc    = 8'($urandom);
         s_ordy  = ($urandom_range(0, 3) != 0);
         s_flush = ($urandom_range(0, 31) == 0);
         s_ee    = ($urandom_range(0, 1) != 0);
         s_ea    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         s_ed    = 16'($urandom);
         s_me    = ($urandom_range(0, 1) != 0);
         s_ma    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         s_md    = 16'($urandom);
         step();
      end

      // halt: sticky until reset, flush ignored
      idle_stim();
      s_ee = 1; s_ea = 4'd2; s_ed = 16'h00AB;
      step();
      idle_stim();
      s_valid = 1; s_inst = 16'hF000;
      for (int k = 0; k < 8; k++) begin
         step();
         if (last_rdy) break;
      end
      chk("halt_accepted", 32'(last_rdy), 1);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_valid", 32'(out_valid), 0);
      s_inst = 16'h1111; s_flush = 1;
      step();
      chk("halt_flush_in_ready", 32'(last_rdy), 0);
      chk("halt_flush_halted", 32'(halted), 1);
      s_flush = 0;
      step();
      do_reset();
      s_valid = 1; s_inst = 16'h1320;
      step();
      chk("post_halt_reset_val1", 32'(out_val1), 0);
      chk("post_halt_reset_val2", 32'(out_val2), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
